// File: rtl/igen_pkg.sv
// Shared types and opcode constants for the immediate generator.
package igen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/igen_core.sv
// Combinational immediate extraction and format/legality classification.
module igen_core
  import igen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     insn_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic            illegal_o
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [31:0] w_imm32;
  logic        w_sh32_ok;
  logic        w_sh64_ok;

  assign w_opc = insn_i[6:0];
  assign w_f3  = insn_i[14:12];

  assign w_sh32_ok = (insn_i[31:25] == 7'h00) ||
                     ((w_f3 == 3'd5) && (insn_i[31:25] == 7'h20));
  assign w_sh64_ok = (insn_i[31:26] == 6'h00) ||
                     ((w_f3 == 3'd5) && (insn_i[31:26] == 6'h10));

  // Every format is the sign extension of a 32-bit value (shamt has bit 31
  // clear), so decode at 32 bits and widen once at the end.
  always_comb begin
    w_imm32   = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;
    if (insn_i[1:0] != 2'b11) begin
      illegal_o = 1'b1;
    end else begin
      unique case (w_opc)
        OPC_LOAD, OPC_MISC_MEM, OPC_JALR, OPC_SYSTEM: begin
          fmt_o   = FMT_I;
          w_imm32 = sext12(insn_i[31:20]);
        end
        OPC_OP_IMM: begin
          if (w_f3 == 3'd1 || w_f3 == 3'd5) begin
            if (RV64 ? w_sh64_ok : w_sh32_ok) begin
              fmt_o   = FMT_SH;
              w_imm32 = RV64 ? {26'd0, insn_i[25:20]} : {27'd0, insn_i[24:20]};
            end else begin
              illegal_o = 1'b1;
            end
          end else begin
            fmt_o   = FMT_I;
            w_imm32 = sext12(insn_i[31:20]);
          end
        end
        OPC_OP_IMM_32: begin
          if (!RV64) begin
            illegal_o = 1'b1;
          end else if (w_f3 == 3'd0) begin
            fmt_o   = FMT_I;
            w_imm32 = sext12(insn_i[31:20]);
          end else if ((w_f3 == 3'd1 || w_f3 == 3'd5) && w_sh32_ok) begin
            fmt_o   = FMT_SH;
            w_imm32 = {27'd0, insn_i[24:20]};
          end else begin
            illegal_o = 1'b1;
          end
        end
        OPC_STORE: begin
          fmt_o   = FMT_S;
          w_imm32 = sext12({insn_i[31:25], insn_i[11:7]});
        end
        OPC_BRANCH: begin
          fmt_o   = FMT_B;
          w_imm32 = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25],
                     insn_i[11:8], 1'b0};
        end
        OPC_JAL: begin
          fmt_o   = FMT_J;
          w_imm32 = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20],
                     insn_i[30:21], 1'b0};
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt_o   = FMT_U;
          w_imm32 = {insn_i[31:12], 12'd0};
        end
        OPC_OP: fmt_o = FMT_R;
        OPC_OP_32: begin
          if (RV64) fmt_o = FMT_R;
          else      illegal_o = 1'b1;
        end
        default: illegal_o = 1'b1;
      endcase
    end
  end

  assign imm_o = XLEN'($signed(w_imm32));

endmodule

// File: rtl/igen_pipe.sv
// Registered immediate generator stage with a one-entry output register plus skid buffer.
module igen_pipe
  import igen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      insn_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output imm_fmt_e         fmt_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_e         fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } igen_out_t;

  localparam igen_out_t OUT_RST = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, tag: '0};

  logic [XLEN-1:0] w_imm;
  imm_fmt_e        w_fmt;
  logic            w_illegal;
  igen_out_t       w_dec;
  igen_out_t       r_out;
  igen_out_t       r_skid;
  logic            r_out_valid;
  logic            r_skid_valid;
  logic            w_accept;
  logic            w_out_free;

  igen_core #(.XLEN(XLEN)) u_core (
    .insn_i    (insn_i),
    .imm_o     (w_imm),
    .fmt_o     (w_fmt),
    .illegal_o (w_illegal)
  );

  assign w_dec      = '{imm: w_imm, fmt: w_fmt, illegal: w_illegal, tag: tag_i};
  assign in_ready_o = ~r_skid_valid;
  assign w_accept   = in_valid_i & in_ready_o;
  assign w_out_free = ~r_out_valid | out_ready_i;

  // A full skid forces in_ready low, so draining it never races a new accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out        <= OUT_RST;
      r_skid       <= OUT_RST;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush_i) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_accept;
        if (w_accept) r_out <= w_dec;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign out_valid_o = r_out_valid;
  assign imm_o       = r_out.imm;
  assign fmt_o       = r_out.fmt;
  assign illegal_o   = r_out.illegal;
  assign tag_o       = r_out.tag;

endmodule

// File: tb/tb_igen_pipe.sv
// Directed bench: RV32 and RV64 instances share stimulus; outputs checked against hand-computed values.
module tb_igen_pipe;
  import igen_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] insn;
  logic [31:0] tag;
  logic        out_ready;

  logic        rdy32, rdy64, ov32, ov64, ill32, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  imm_fmt_e    fmt32, fmt64;
  logic [31:0] tag32, tag64;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  igen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy32), .insn_i(insn), .tag_i(tag), .out_valid_o(ov32),
    .out_ready_i(out_ready), .imm_o(imm32), .fmt_o(fmt32), .illegal_o(ill32),
    .tag_o(tag32)
  );

  igen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy64), .insn_i(insn), .tag_i(tag), .out_valid_o(ov64),
    .out_ready_i(out_ready), .imm_o(imm64), .fmt_o(fmt64), .illegal_o(ill64),
    .tag_o(tag64)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hs(input string name, input logic ov, input logic rdy, input logic [31:0] t);
    chk({name, " ov32"}, ov32, ov);
    chk({name, " ov64"}, ov64, ov);
    chk({name, " rdy32"}, rdy32, rdy);
    chk({name, " rdy64"}, rdy64, rdy);
    if (ov) begin
      chk({name, " tag32"}, tag32, t);
      chk({name, " tag64"}, tag64, t);
    end
  endtask

  // One instruction through both instances with out_ready high.
  task automatic vec(input string name, input logic [31:0] i,
                     input logic [63:0] e_imm32, input imm_fmt_e e_fmt32, input logic e_ill32,
                     input logic [63:0] e_imm64, input imm_fmt_e e_fmt64, input logic e_ill64);
    tag      = tag + 1;
    insn     = i;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_hs(name, 1'b1, 1'b1, tag);
    chk({name, " imm32"}, imm32, e_imm32);
    chk({name, " fmt32"}, fmt32, e_fmt32);
    chk({name, " ill32"}, ill32, e_ill32);
    chk({name, " imm64"}, imm64, e_imm64);
    chk({name, " fmt64"}, fmt64, e_fmt64);
    chk({name, " ill64"}, ill64, e_ill64);
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    insn      = 32'h0;
    tag       = 32'h0;
    out_ready = 1'b1;

    #12;
    chk("rst ov32", ov32, 1'b0);
    chk("rst ov64", ov64, 1'b0);
    chk("rst imm64", imm64, 64'h0);
    chk("rst fmt32", fmt32, FMT_NONE);
    chk("rst ill64", ill64, 1'b0);
    chk("rst tag32", tag32, 32'h0);
    @(negedge clk) reset_n = 1'b1;
    tick();
    chk_hs("rst rel", 1'b0, 1'b1, 32'h0);

    tag = 32'h100;
    vec("addi",    32'hFFF00093, 64'hFFFFFFFF, FMT_I, 1'b0, 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0);
    vec("beq",     32'hFE000EE3, 64'hFFFFFFFC, FMT_B, 1'b0, 64'hFFFFFFFFFFFFFFFC, FMT_B, 1'b0);
    vec("lui",     32'h800000B7, 64'h80000000, FMT_U, 1'b0, 64'hFFFFFFFF80000000, FMT_U, 1'b0);
    vec("auipc",   32'h12345097, 64'h12345000, FMT_U, 1'b0, 64'h12345000, FMT_U, 1'b0);
    vec("srai",    32'h4030D093, 64'h3, FMT_SH, 1'b0, 64'h3, FMT_SH, 1'b0);
    vec("srai f7", 32'h2030D093, 64'h0, FMT_NONE, 1'b1, 64'h0, FMT_NONE, 1'b1);
    vec("srai 35", 32'h4230D093, 64'h0, FMT_NONE, 1'b1, 64'd35, FMT_SH, 1'b0);
    vec("slli 32", 32'h02009093, 64'h0, FMT_NONE, 1'b1, 64'd32, FMT_SH, 1'b0);
    vec("addiw",   32'hFFF0809B, 64'h0, FMT_NONE, 1'b1, 64'hFFFFFFFFFFFFFFFF, FMT_I, 1'b0);
    vec("sraiw",   32'h4030D09B, 64'h0, FMT_NONE, 1'b1, 64'h3, FMT_SH, 1'b0);
    vec("add",     32'h002081B3, 64'h0, FMT_R, 1'b0, 64'h0, FMT_R, 1'b0);
    vec("addw",    32'h002081BB, 64'h0, FMT_NONE, 1'b1, 64'h0, FMT_R, 1'b0);
    vec("sw +12",  32'h00112623, 64'd12, FMT_S, 1'b0, 64'd12, FMT_S, 1'b0);
    vec("sw -4",   32'hFE112E23, 64'hFFFFFFFC, FMT_S, 1'b0, 64'hFFFFFFFFFFFFFFFC, FMT_S, 1'b0);
    vec("jal -8",  32'hFF9FF0EF, 64'hFFFFFFF8, FMT_J, 1'b0, 64'hFFFFFFFFFFFFFFF8, FMT_J, 1'b0);
    vec("ecall",   32'h00000073, 64'h0, FMT_I, 1'b0, 64'h0, FMT_I, 1'b0);
    vec("lb 0",    32'h00000003, 64'h0, FMT_I, 1'b0, 64'h0, FMT_I, 1'b0);
    vec("zero",    32'h00000000, 64'h0, FMT_NONE, 1'b1, 64'h0, FMT_NONE, 1'b1);
    vec("opc 7f",  32'h0000007F, 64'h0, FMT_NONE, 1'b1, 64'h0, FMT_NONE, 1'b1);
    tick();
    chk_hs("drain", 1'b0, 1'b1, 32'h0);

    // Backpressure: tag1 on output, tag2 in skid, tag3 waits.
    insn = 32'hFFF00093;
    out_ready = 1'b0;
    in_valid = 1'b1; tag = 32'd1;
    tick(); chk_hs("bp t1", 1'b1, 1'b1, 32'd1);
    tag = 32'd2;
    tick(); chk_hs("bp t2 skid", 1'b1, 1'b0, 32'd1);
    tag = 32'd3;
    tick(); chk_hs("bp hold a", 1'b1, 1'b0, 32'd1);
    tick(); chk_hs("bp hold b", 1'b1, 1'b0, 32'd1);
    chk("bp imm32 stable", imm32, 32'hFFFFFFFF);
    out_ready = 1'b1;
    tick(); chk_hs("bp rel t2", 1'b1, 1'b1, 32'd2);
    tick(); chk_hs("bp rel t3", 1'b1, 1'b1, 32'd3);
    in_valid = 1'b0;
    tick(); chk_hs("bp empty", 1'b0, 1'b1, 32'h0);

    // Flush with skid full.
    out_ready = 1'b0;
    in_valid = 1'b1; tag = 32'd4;
    tick(); tag = 32'd5;
    tick(); chk_hs("fl full", 1'b1, 1'b0, 32'd4);
    tag = 32'd6; flush = 1'b1;
    tick(); chk_hs("fl clear", 1'b0, 1'b1, 32'h0);
    flush = 1'b0; in_valid = 1'b0;
    tick(); chk_hs("fl stays", 1'b0, 1'b1, 32'h0);

    // Flush discards a same-cycle accept.
    in_valid = 1'b1; tag = 32'd7;
    tick(); chk_hs("fl t7", 1'b1, 1'b1, 32'd7);
    tag = 32'd8; flush = 1'b1;
    tick(); chk_hs("fl disc", 1'b0, 1'b1, 32'h0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); chk_hs("fl no t8", 1'b0, 1'b1, 32'h0);

    // Async reset mid-stream.
    out_ready = 1'b0;
    in_valid = 1'b1; tag = 32'd9;
    tick(); tag = 32'd10;
    tick(); chk_hs("ar full", 1'b1, 1'b0, 32'd9);
    #2 reset_n = 1'b0;
    #1;
    chk_hs("ar async", 1'b0, 1'b1, 32'h0);
    chk("ar tag64", tag64, 32'h0);
    chk("ar imm64", imm64, 64'h0);
    chk("ar fmt32", fmt32, FMT_NONE);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk) reset_n = 1'b1;
    tick(); chk_hs("ar after", 1'b0, 1'b1, 32'h0);

    // Illegal entry held under stall, then handshaked out.
    out_ready = 1'b0;
    insn = 32'h0000007F; in_valid = 1'b1; tag = 32'd11;
    tick(); in_valid = 1'b0;
    tick(); chk_hs("ill hold", 1'b1, 1'b1, 32'd11);
    chk("ill hold ill32", ill32, 1'b1);
    chk("ill hold fmt64", fmt64, FMT_NONE);
    out_ready = 1'b1;
    tick(); chk_hs("ill rel", 1'b0, 1'b1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
